pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Sequencer for the PC-source mux in the IF stage. Each cycle it picks pc_src_sel (`PCSRC_* from
//  ctrl_encode_def.v) and pc_we from branch/jump/illegal-op/interrupt events, prioritised by age.
//  Owns the interrupt-entry FSM (sync, drain, redirect, handler mask) and issues stage flushes and EPC writes.
// PARAMETERS
//  DRAIN_CYCLES  2  cycles IF/ID are flushed before vectoring to xadr (lets EX/MEM/WB retire); >=1
//  SYNC_STAGES   2  flops in the irq synchroniser; >=1
// PORTS
//  clk           in   1  clock; all state on rising edge
//  rst           in   1  synchronous, active-high reset
//  stall         in   1  hazard-unit hold of IF/ID
//  irq           in   1  external interrupt request, level, asynchronous
//  irq_en        in   1  global interrupt enable
//  illop_id      in   1  ID instruction is an illegal opcode
//  jr_id         in   1  ID instruction is jr/jalr
//  j_id          in   1  ID instruction is j/jal
//  eret_id       in   1  ID instruction is eret (return from handler)
//  br_taken_ex   in   1  EX branch resolved taken
//  pc_src_sel    out  3  PC mux select, `PCSRC_* encoding
//  pc_we         out  1  PC register load enable
//  flush_if      out  1  kill IF/ID register contents
//  flush_id      out  1  kill ID/EX register contents
//  epc_we        out  1  one-cycle EPC write strobe
//  epc_sel       out  1  EPC source: 0 = ID-stage PC, 1 = IF-stage PC
//  in_handler    out  1  registered; high from vectoring until eret accepted
// BEHAVIOUR
//  Reset: state=RUN, sync chain=0, drain count=0, in_handler=0. While rst high: pc_src_sel=`PCSRC_PLUS4,
//   pc_we=0, all flushes/epc_we/epc_sel=0. First cycle after rst falls: pc_we=1, sel PLUS4.
//  irq_s = irq after SYNC_STAGES flops (latency SYNC_STAGES cycles). Other inputs used same-cycle.
//  FSM states: RUN, DRAIN, REDIR, HANDLER. Outputs combinational from state + inputs.
//  RUN/HANDLER priority (first match wins):
//   1 br_taken_ex: sel BT, pc_we=1, flush_if=1, flush_id=1. Overrides stall.
//   2 stall: pc_we=0, no flushes; all ID events ignored (ID instr is reissued).
//   3 illop_id: sel ILLOP, pc_we=1, flush_if=1, flush_id=1, epc_we=1, epc_sel=0; next HANDLER.
//   4 jr_id: sel JR, pc_we=1, flush_if=1.   5 j_id: sel JT, pc_we=1, flush_if=1.
//   6 else: sel PLUS4, pc_we=1.
//  Interrupt entry (RUN only): irq_s & irq_en & no row 1-5 event this cycle -> epc_we=1, epc_sel=1,
//   pc_we=0, flush_if=1, flush_id=1; next DRAIN with count=DRAIN_CYCLES-1. Any row 1-5 event defers
//   entry by one cycle (re-evaluated each cycle, irq level).
//  DRAIN: pc_we=0, flush_if=flush_id=1; all inputs ignored (br_taken_ex cannot occur: ID/EX flushed).
//   Count down; at 0 -> REDIR.
//  REDIR (1 cycle): sel XADR, pc_we=1, flush_if=1; next HANDLER, in_handler<=1.
//  HANDLER: rows 1-6 as RUN; interrupts masked. eret_id with no row 1-2 match -> row-6 outputs,
//   next RUN, in_handler<=0; irq can enter no earlier than the following cycle. illop in HANDLER
//   re-vectors to ILLOP, stays HANDLER.
//  Simultaneous ID events (illop+jr etc.) resolved by priority; only one epc_we per event.
//  rst mid-DRAIN/REDIR/HANDLER: returns to RUN next cycle, no EPC write, mask cleared.
//  pc_src_sel never X; undefined state -> RUN.
// TESTING
//  T1 rst 3 cycles, release -> cycle 0 after: pc_we=1, sel PLUS4, in_handler=0, no flush.
//  T2 j_id=1 & br_taken_ex=1 same cycle -> sel BT, flush_if=flush_id=1; next cycle j ignored.
//  T3 stall=1 with jr_id=1 for 3 cycles -> pc_we=0 x3; stall drops -> sel JR, pc_we=1, flush_if=1.
//  T4 irq pulse while RUN, irq_en=1, DRAIN_CYCLES=2 -> after SYNC_STAGES cycles epc_we (epc_sel=1),
//     2 DRAIN cycles pc_we=0, then 1 cycle sel XADR pc_we=1, then in_handler=1.
//  T5 HANDLER with irq held high -> no re-entry; eret_id -> RUN; re-entry starts next cycle.
//  T6 illop_id in RUN -> sel ILLOP, epc_we=1, epc_sel=0, in_handler=1 next; rst in HANDLER -> in_handler=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : IF-stage PC-source sequencer. Selects the PC mux source and
//               the PC load enable from branch, jump, illegal-op and interrupt
//               events, oldest event first. Runs the interrupt-entry FSM
//               (synchronise, drain, redirect, handler mask) and drives the
//               stage flushes and EPC write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  logic       i_irq,
    input  logic       i_irq_en,
    input  logic       i_illop_id,
    input  logic       i_jr_id,
    input  logic       i_j_id,
    input  logic       i_eret_id,
    input  logic       i_br_taken_ex,
    output logic [2:0] o_pc_src_sel,
    output logic       o_pc_we,
    output logic       o_flush_if,
    output logic       o_flush_id,
    output logic       o_epc_we,
    output logic       o_epc_sel,
    output logic       o_in_handler
);

    // PC mux source encoding shared with the IF-stage mux
    localparam logic [2:0] c_PCSRC_PLUS4 = 3'd0;
    localparam logic [2:0] c_PCSRC_BT    = 3'd1;
    localparam logic [2:0] c_PCSRC_JR    = 3'd2;
    localparam logic [2:0] c_PCSRC_JT    = 3'd3;
    localparam logic [2:0] c_PCSRC_ILLOP = 3'd4;
    localparam logic [2:0] c_PCSRC_XADR  = 3'd5;

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_REDIR   = 2'd2,
        S_HANDLER = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_drain_cnt;
    logic [CNT_W-1:0]       w_drain_cnt_next;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic                   r_in_handler;
    logic                   w_irq_s;

    logic [2:0]             w_sel;
    logic                   w_pc_we;
    logic                   w_flush_if;
    logic                   w_flush_id;
    logic                   w_epc_we;
    logic                   w_epc_sel;

    assign w_irq_s = r_irq_sync[SYNC_STAGES-1];

    // Synchronise the asynchronous interrupt level into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_sync <= '0;
        end else begin
            r_irq_sync[0] <= i_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_irq_sync[i] <= r_irq_sync[i-1];
            end
        end
    end

    // State, drain counter and handler mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_drain_cnt  <= '0;
            r_in_handler <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drain_cnt  <= w_drain_cnt_next;
            r_in_handler <= (w_state_next == S_HANDLER);
        end
    end

    // Event priority, interrupt entry and next-state decode
    always_comb begin
        w_sel            = c_PCSRC_PLUS4;
        w_pc_we          = 1'b0;
        w_flush_if       = 1'b0;
        w_flush_id       = 1'b0;
        w_epc_we         = 1'b0;
        w_epc_sel        = 1'b0;
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;

        case (r_state)
            S_RUN, S_HANDLER: begin
                if (i_br_taken_ex) begin
                    // Oldest event: the taken branch in EX kills both younger stages
                    w_sel      = c_PCSRC_BT;
                    w_pc_we    = 1'b1;
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                end else if (i_stall) begin
                    // ID instruction will be reissued, so its events wait
                    w_pc_we = 1'b0;
                end else if ((r_state == S_HANDLER) && i_eret_id) begin
                    w_pc_we      = 1'b1;
                    w_state_next = S_RUN;
                end else if (i_illop_id) begin
                    w_sel        = c_PCSRC_ILLOP;
                    w_pc_we      = 1'b1;
                    w_flush_if   = 1'b1;
                    w_flush_id   = 1'b1;
                    w_epc_we     = 1'b1;
                    w_epc_sel    = 1'b0;
                    w_state_next = S_HANDLER;
                end else if (i_jr_id) begin
                    w_sel      = c_PCSRC_JR;
                    w_pc_we    = 1'b1;
                    w_flush_if = 1'b1;
                end else if (i_j_id) begin
                    w_sel      = c_PCSRC_JT;
                    w_pc_we    = 1'b1;
                    w_flush_if = 1'b1;
                end else if ((r_state == S_RUN) && w_irq_s && i_irq_en) begin
                    // Interrupt entry: save the IF-stage PC and start draining
                    w_pc_we          = 1'b0;
                    w_flush_if       = 1'b1;
                    w_flush_id       = 1'b1;
                    w_epc_we         = 1'b1;
                    w_epc_sel        = 1'b1;
                    w_state_next     = S_DRAIN;
                    w_drain_cnt_next = c_DRAIN_LOAD;
                end else begin
                    w_pc_we = 1'b1;
                end
            end
            S_DRAIN: begin
                // Hold the PC while EX/MEM/WB retire; younger stages stay empty
                w_flush_if = 1'b1;
                w_flush_id = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_next = S_REDIR;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 1'b1;
                end
            end
            S_REDIR: begin
                w_sel        = c_PCSRC_XADR;
                w_pc_we      = 1'b1;
                w_flush_if   = 1'b1;
                w_state_next = S_HANDLER;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase

        if (rst) begin
            w_sel      = c_PCSRC_PLUS4;
            w_pc_we    = 1'b0;
            w_flush_if = 1'b0;
            w_flush_id = 1'b0;
            w_epc_we   = 1'b0;
            w_epc_sel  = 1'b0;
        end
    end

    assign o_pc_src_sel = w_sel;
    assign o_pc_we      = w_pc_we;
    assign o_flush_if   = w_flush_if;
    assign o_flush_id   = w_flush_id;
    assign o_epc_we     = w_epc_we;
    assign o_epc_sel    = w_epc_sel;
    assign o_in_handler = r_in_handler;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Directed self-checking bench for pc_redirect_ctrl. Expected
//               output vectors are queued as each step is driven and popped
//               when the DUT outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

    localparam logic [2:0] c_P4 = 3'd0;
    localparam logic [2:0] c_BT = 3'd1;
    localparam logic [2:0] c_JR = 3'd2;
    localparam logic [2:0] c_JT = 3'd3;
    localparam logic [2:0] c_IL = 3'd4;
    localparam logic [2:0] c_XA = 3'd5;

    logic       clk;
    logic       rst;
    logic       r_stall, r_irq, r_irq_en, r_illop, r_jr, r_j, r_eret, r_br;
    logic [2:0] w_sel;
    logic       w_pc_we, w_flush_if, w_flush_id, w_epc_we, w_epc_sel, w_in_handler;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    int         errors = 0;
    int         checks = 0;

    pc_redirect_ctrl #(
        .DRAIN_CYCLES (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (r_stall),
        .i_irq         (r_irq),
        .i_irq_en      (r_irq_en),
        .i_illop_id    (r_illop),
        .i_jr_id       (r_jr),
        .i_j_id        (r_j),
        .i_eret_id     (r_eret),
        .i_br_taken_ex (r_br),
        .o_pc_src_sel  (w_sel),
        .o_pc_we       (w_pc_we),
        .o_flush_if    (w_flush_if),
        .o_flush_id    (w_flush_id),
        .o_epc_we      (w_epc_we),
        .o_epc_sel     (w_epc_sel),
        .o_in_handler  (w_in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack an expected vector: {sel, pc_we, flush_if, flush_id, epc_we, epc_sel, in_handler}
    function automatic logic [8:0] mk(input logic [2:0] sel, input logic we, input logic fif,
                                      input logic fid, input logic ew, input logic es,
                                      input logic inh);
        return {sel, we, fif, fid, ew, es, inh};
    endfunction

    task automatic drive(input logic rs, input logic st, input logic iq, input logic ie,
                         input logic il, input logic jr, input logic j, input logic er,
                         input logic br);
        rst      = rs;
        r_stall  = st;
        r_irq    = iq;
        r_irq_en = ie;
        r_illop  = il;
        r_jr     = jr;
        r_j      = j;
        r_eret   = er;
        r_br     = br;
    endtask

    // Queue the expectation, sample on the falling edge, then advance past the next rising edge
    task automatic step(input string tag, input logic [8:0] exp);
        sb_entry_t  e;
        logic [8:0] obs;
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        e   = sb_q.pop_front();
        obs = {w_sel, w_pc_we, w_flush_if, w_flush_id, w_epc_we, w_epc_sel, w_in_handler};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed sel/we/fif/fid/ew/es/inh=%b expected=%b", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held three cycles, then release
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_c0",      mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_c1",      mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_c2",      mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_rst",    mk(c_P4, 1, 0, 0, 0, 0, 0));

        // Branch in EX beats a jump in ID
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); step("br_over_j",   mk(c_BT, 1, 1, 1, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("after_br",    mk(c_P4, 1, 0, 0, 0, 0, 0));

        // Stall holds a jr for three cycles, then it issues
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0); step("stall_jr0",   mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0); step("stall_jr1",   mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0); step("stall_jr2",   mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0); step("jr_issue",    mk(c_JR, 1, 1, 0, 0, 0, 0));

        // One-cycle irq pulse: two synchroniser cycles, entry, two drain cycles, redirect
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("irq_sync0",   mk(c_P4, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step("irq_sync1",   mk(c_P4, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step("irq_entry",   mk(c_P4, 0, 1, 1, 1, 1, 0));
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0); step("drain0_jr",   mk(c_P4, 0, 1, 1, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step("drain1",      mk(c_P4, 0, 1, 1, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step("redir",       mk(c_XA, 1, 1, 0, 0, 0, 0));

        // Handler with irq held high: masked until eret
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("hdl_mask0",   mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("hdl_mask1",   mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("hdl_mask2",   mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(0, 0, 1, 1, 0, 0, 0, 1, 0); step("eret",        mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(0, 0, 1, 1, 0, 0, 1, 0, 0); step("irq_defer_j", mk(c_JT, 1, 1, 0, 0, 0, 0));
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("reentry",     mk(c_P4, 0, 1, 1, 1, 1, 0));

        // Reset in the middle of a drain returns to RUN with a cleared synchroniser
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0); step("rst_drain",   mk(c_P4, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step("post_rst2",   mk(c_P4, 1, 0, 0, 0, 0, 0));

        // Illegal op with a simultaneous jr, then handler behaviour
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0); step("illop_jr",    mk(c_IL, 1, 1, 1, 1, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("hdl_idle",    mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(0, 1, 0, 0, 1, 0, 0, 0, 0); step("hdl_stall_il",mk(c_P4, 0, 0, 0, 0, 0, 1));
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step("hdl_illop",   mk(c_IL, 1, 1, 1, 1, 0, 1));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step("hdl_br_eret", mk(c_BT, 1, 1, 1, 0, 0, 1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("hdl_still",   mk(c_P4, 1, 0, 0, 0, 0, 1));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_hdl",     mk(c_P4, 0, 0, 0, 0, 0, 1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_rst3",   mk(c_P4, 1, 0, 0, 0, 0, 0));

        // Interrupt disabled: no entry even with irq synchronised
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step("irq_dis0",    mk(c_P4, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step("irq_dis1",    mk(c_P4, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step("irq_dis2",    mk(c_P4, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step("irq_enable",  mk(c_P4, 0, 1, 1, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
